// File: rtl/tri_l2_responder_if.sv
// TRI request/response and host-write bundle between the coherency side
// and the L2 responder.
interface tri_l2_responder_if #(
  parameter int MSHR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_type;
  logic [39:0]       req_addr;
  logic [127:0]      req_data;
  logic [MSHR_W-1:0] req_mshrid;

  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_type;
  logic [MSHR_W-1:0] resp_mshrid;
  logic [39:0]       resp_addr;
  logic [127:0]      resp_data;

  logic              ext_wr_valid;
  logic              ext_wr_ready;
  logic [39:0]       ext_wr_addr;
  logic [127:0]      ext_wr_data;

  modport master (
    output req_valid, req_type, req_addr,
    output req_data, req_mshrid,
    input  req_ready,
    input  resp_valid, resp_type, resp_mshrid,
    input  resp_addr, resp_data,
    output resp_ready,
    output ext_wr_valid, ext_wr_addr, ext_wr_data,
    input  ext_wr_ready
  );

  modport slave (
    input  req_valid, req_type, req_addr,
    input  req_data, req_mshrid,
    output req_ready,
    output resp_valid, resp_type, resp_mshrid,
    output resp_addr, resp_data,
    input  resp_ready,
    input  ext_wr_valid, ext_wr_addr, ext_wr_data,
    output ext_wr_ready
  );
endinterface

// File: rtl/tri_l2_responder.sv
// L2-side TRI responder: small line store with a one-sharer directory,
// fixed-latency load/store service and invalidations on line change.
module tri_l2_responder #(
  parameter int IDX_W   = 4,
  parameter int MSHR_W  = 3,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  tri_l2_responder_if.slave bus
);

  localparam int NL = 1 << IDX_W;

  localparam logic [1:0] RT_LOAD = 2'd0;
  localparam logic [1:0] RT_ACK  = 2'd1;
  localparam logic [1:0] RT_INV  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_INV,
    S_RESP,
    S_EXTINV
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              type_q;
  logic [39:4]       la_q;
  logic [127:0]      data_q;
  logic [MSHR_W-1:0] id_q;

  logic [127:0]      line_q   [NL];
  logic [MSHR_W-1:0] shr_id_q [NL];
  logic [NL-1:0]     shr_v_q;

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  ext_idx;
  logic [IDX_W-1:0]  chk_idx;
  logic [MSHR_W-1:0] chk_id;
  logic              conflict;
  state_t            post_st;

  logic ext_acc, req_acc, inv_hs, done_hs;
  logic req_rdy, ext_rdy, rsp_v;
  logic [1:0]        rsp_t;
  logic [MSHR_W-1:0] rsp_id;
  logic [127:0]      rsp_d;

  logic unused_lowbits;

  assign unused_lowbits = ^{bus.req_addr[3:0],
                            bus.ext_wr_addr[3:0]};

  assign idx_q   = la_q[4 +: IDX_W];
  assign ext_idx = bus.ext_wr_addr[4 +: IDX_W];

  // With LATENCY==1 the check happens in the accept cycle itself,
  // so it must look at the incoming request rather than the capture.
  assign chk_idx = (state_q == S_IDLE) ?
                   bus.req_addr[4 +: IDX_W] : idx_q;
  assign chk_id  = (state_q == S_IDLE) ? bus.req_mshrid : id_q;
  assign conflict = shr_v_q[chk_idx] &&
                    (shr_id_q[chk_idx] != chk_id);
  assign post_st  = conflict ? S_INV : S_RESP;

  // Next-state, handshakes and response fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_acc = 1'b0;
    req_acc = 1'b0;
    inv_hs  = 1'b0;
    done_hs = 1'b0;
    req_rdy = 1'b0;
    ext_rdy = 1'b0;
    rsp_v   = 1'b0;
    rsp_t   = RT_LOAD;
    rsp_id  = id_q;
    rsp_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        ext_rdy = !rst;
        req_rdy = !rst && !bus.ext_wr_valid;
        if (ext_rdy && bus.ext_wr_valid) begin
          ext_acc = 1'b1;
          state_d = shr_v_q[ext_idx] ? S_EXTINV : S_IDLE;
        end else if (req_rdy && bus.req_valid) begin
          req_acc = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? post_st : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = post_st;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_INV, S_EXTINV: begin
        rsp_v  = 1'b1;
        rsp_t  = RT_INV;
        rsp_id = shr_id_q[idx_q];
        if (bus.resp_ready) begin
          inv_hs  = 1'b1;
          state_d = (state_q == S_INV) ? S_RESP : S_IDLE;
        end
      end
      S_RESP: begin
        rsp_v = 1'b1;
        rsp_t = type_q ? RT_ACK : RT_LOAD;
        rsp_d = type_q ? '0 : line_q[idx_q];
        if (bus.resp_ready) begin
          done_hs = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready    = req_rdy;
  assign bus.ext_wr_ready = ext_rdy;
  assign bus.resp_valid   = rsp_v && !rst;
  assign bus.resp_type    = rsp_t;
  assign bus.resp_mshrid  = rsp_id;
  assign bus.resp_addr    = {la_q, 4'h0};
  assign bus.resp_data    = rsp_d;

  // Control state and captured transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      la_q    <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ext_acc) begin
        la_q <= bus.ext_wr_addr[39:4];
      end
      if (req_acc) begin
        type_q <= bus.req_type;
        la_q   <= bus.req_addr[39:4];
        data_q <= bus.req_data;
        id_q   <= bus.req_mshrid;
      end
    end
  end

  // Line store and sharer directory.
  always_ff @(posedge clk) begin
    if (rst) begin
      shr_v_q <= '0;
      for (int i = 0; i < NL; i++) begin
        line_q[i]   <= '0;
        shr_id_q[i] <= '0;
      end
    end else begin
      if (ext_acc) begin
        line_q[ext_idx] <= bus.ext_wr_data;
      end
      if (inv_hs) begin
        shr_v_q[idx_q] <= 1'b0;
      end
      if (done_hs) begin
        shr_v_q[idx_q]  <= 1'b1;
        shr_id_q[idx_q] <= id_q;
        if (type_q) begin
          line_q[idx_q] <= data_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_l2_responder.sv
// Randomized bench for tri_l2_responder with a queue-based line/sharer
// model and a second LATENCY=1 instance for back-to-back throughput.
module tb_tri_l2_responder;

  localparam int IDX_W  = 4;
  localparam int MSHR_W = 3;
  localparam int LAT    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  tri_l2_responder_if #(.MSHR_W(MSHR_W)) bus ();
  tri_l2_responder_if #(.MSHR_W(MSHR_W)) b1 ();

  tri_l2_responder #(
    .IDX_W(IDX_W), .MSHR_W(MSHR_W), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  tri_l2_responder #(
    .IDX_W(IDX_W), .MSHR_W(MSHR_W), .LATENCY(1)
  ) u1 (
    .clk(clk), .rst(rst1), .bus(b1.slave)
  );

  typedef struct {
    logic [1:0]   t;
    logic [2:0]   id;
    logic [39:0]  a;
    logic [127:0] d;
    int           at;
  } rsp_t;

  rsp_t expq[$];
  rsp_t logq[$];

  logic [127:0] mem  [16];
  bit           shv  [16];
  logic [2:0]   shid [16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hold_lo = 0;
  bit rdy_rand = 1'b0;
  bit l1_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [127:0] act,
                       logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = '0;
      shv[i]  = 1'b0;
      shid[i] = '0;
    end
  endtask

  function automatic rsp_t mk(logic [1:0] t, logic [2:0] id,
                              logic [39:0] a, logic [127:0] d,
                              int at);
    rsp_t r;
    r.t = t; r.id = id; r.a = {a[39:4], 4'h0};
    r.d = d; r.at = at;
    return r;
  endfunction

  // Host write: line updated, current sharer (if any) invalidated.
  task automatic m_ext(logic [39:0] a, logic [127:0] d, int c);
    int i;
    i = int'(a[7:4]);
    mem[i] = d;
    if (shv[i]) begin
      expq.push_back(mk(2'd2, shid[i], a, '0, c + 1));
      shv[i] = 1'b0;
    end
  endtask

  // Load/store: optional inv to a different sharer, then the reply;
  // the requester always ends up as the sole sharer.
  task automatic m_req(bit st, logic [39:0] a, logic [127:0] d,
                       logic [2:0] id, int c);
    int i;
    int at;
    i  = int'(a[7:4]);
    at = c + LAT;
    if (shv[i] && shid[i] != id) begin
      expq.push_back(mk(2'd2, shid[i], a, '0, at));
      at = -1;
    end
    if (st) begin
      expq.push_back(mk(2'd1, id, a, '0, at));
      mem[i] = d;
    end else begin
      expq.push_back(mk(2'd0, id, a, mem[i], at));
    end
    shv[i]  = 1'b1;
    shid[i] = id;
  endtask

  // Drives one ext write and/or one request; returns after acceptance.
  task automatic xact(bit de, logic [39:0] ea, logic [127:0] ed,
                      bit dr, bit st, logic [39:0] ra,
                      logic [127:0] rd, logic [2:0] rid);
    int n;
    bit ea_acc, ra_acc;
    n = 0;
    bus.ext_wr_valid = de;
    bus.ext_wr_addr  = ea;
    bus.ext_wr_data  = ed;
    bus.req_valid    = dr;
    bus.req_type     = st;
    bus.req_addr     = ra;
    bus.req_data     = rd;
    bus.req_mshrid   = rid;
    while ((bus.ext_wr_valid || bus.req_valid) && n < 300) begin
      @(negedge clk);
      ea_acc = bus.ext_wr_valid && bus.ext_wr_ready;
      ra_acc = bus.req_valid && bus.req_ready;
      if (bus.ext_wr_valid && bus.req_valid)
        check("ext_prio", {127'd0, bus.req_ready}, 128'd0);
      if (ea_acc) m_ext(ea, ed, cyc);
      if (ra_acc) m_req(st, ra, rd, rid, cyc);
      @(posedge clk);
      #1;
      if (ea_acc) bus.ext_wr_valid = 1'b0;
      if (ra_acc) bus.req_valid = 1'b0;
      n++;
    end
    if (n >= 300) begin
      check("accept_timeout", 128'd0, 128'd1);
      bus.ext_wr_valid = 1'b0;
      bus.req_valid    = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 128'(expq.size()), 128'd0);
  endtask

  // Per-cycle compare of the response channel against the model queue.
  initial begin
    int last_hs;
    bit cur_seen, prev_v, prev_r, rdy;
    logic [1:0]   pt;
    logic [2:0]   pid;
    logic [39:0]  pa;
    logic [127:0] pd;
    rsp_t e, o;
    last_hs = 0; cur_seen = 0; prev_v = 0; prev_r = 0;
    pt = '0; pid = '0; pa = '0; pd = '0;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_resp_valid", {127'd0, bus.resp_valid}, 128'd0);
        check("rst_req_ready", {127'd0, bus.req_ready}, 128'd0);
        expq.delete();
        cur_seen = 0; prev_v = 0;
        bus.resp_ready = 1'b0;
        continue;
      end
      if (bus.resp_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_resp", 128'd1, 128'd0);
        end else begin
          e = expq[0];
          if (!cur_seen) begin
            check("resp_time", 128'(cyc),
                  128'(e.at >= 0 ? e.at : last_hs + 1));
            cur_seen = 1;
          end
          check("resp_type", 128'(bus.resp_type), 128'(e.t));
          check("resp_id", 128'(bus.resp_mshrid), 128'(e.id));
          check("resp_addr", 128'(bus.resp_addr), 128'(e.a));
          check("resp_data", bus.resp_data, e.d);
        end
        if (prev_v && !prev_r) begin
          check("hold_stable",
                {bus.resp_type, bus.resp_mshrid,
                 bus.resp_addr, bus.resp_data[80:0]},
                {pt, pid, pa, pd[80:0]});
        end
      end
      if (hold_lo > 0 && bus.resp_valid) begin
        rdy = 1'b0;
        hold_lo--;
      end else begin
        rdy = rdy_rand ? (($urandom % 4) != 0) : 1'b1;
      end
      bus.resp_ready = rdy;
      if (bus.resp_valid && rdy && expq.size() > 0) begin
        void'(expq.pop_front());
        o = mk(bus.resp_type, bus.resp_mshrid, bus.resp_addr,
               bus.resp_data, cyc);
        logq.push_back(o);
        last_hs = cyc;
        cur_seen = 0;
      end
      prev_v = bus.resp_valid;
      prev_r = rdy;
      pt = bus.resp_type; pid = bus.resp_mshrid;
      pa = bus.resp_addr; pd = bus.resp_data;
    end
  end

  // LATENCY=1 instance: continuous loads, one reply every 2 cycles.
  initial begin
    int acc_c[$];
    logic [2:0] aid[$];
    int got, last_r, n, id_n;
    bit acc;
    got = 0; last_r = -1; n = 0; id_n = 1;
    b1.req_valid = 1'b0; b1.req_type = 1'b0;
    b1.req_data = '0; b1.req_mshrid = 3'd1;
    b1.req_addr = 40'h10;
    b1.ext_wr_valid = 1'b0; b1.ext_wr_addr = '0;
    b1.ext_wr_data = '0; b1.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    b1.req_valid = 1'b1;
    while (got < 12 && n < 200) begin
      @(negedge clk);
      n++;
      if (b1.resp_valid) begin
        if (aid.size() == 0) begin
          check("l1_unexpected", 128'd1, 128'd0);
        end else begin
          check("l1_type", 128'(b1.resp_type), 128'd0);
          check("l1_id", 128'(b1.resp_mshrid), 128'(aid[0]));
          check("l1_data", b1.resp_data, 128'd0);
          check("l1_time", 128'(cyc), 128'(acc_c[0] + 1));
          if (last_r >= 0)
            check("l1_gap", 128'(cyc - last_r), 128'd2);
          last_r = cyc;
          void'(aid.pop_front());
          void'(acc_c.pop_front());
          got++;
        end
      end
      acc = b1.req_valid && b1.req_ready;
      if (acc) begin
        acc_c.push_back(cyc);
        aid.push_back(b1.req_mshrid);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        id_n = id_n % 7 + 1;
        b1.req_mshrid = 3'(id_n);
        b1.req_addr = 40'(id_n) << 4;
      end
    end
    check("l1_count", 128'(got), 128'd12);
    b1.req_valid = 1'b0;
    l1_done = 1'b1;
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int n0, n;
    logic [127:0] pat, xd;
    logic [63:0]  r64;
    logic [39:0]  ad;
    rsp_t q;
    bus.req_valid = 1'b0; bus.req_type = 1'b0;
    bus.req_addr = '0; bus.req_data = '0; bus.req_mshrid = '0;
    bus.ext_wr_valid = 1'b0; bus.ext_wr_addr = '0;
    bus.ext_wr_data = '0;
    model_reset();
    pat = {4{32'hA5A5A5A5}};
    xd  = {4{32'h3C3CC3C3}};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {127'd0, bus.req_ready}, 128'd1);
    check("post_rst_resp_valid", {127'd0, bus.resp_valid}, 128'd0);
    @(posedge clk);
    #1;

    xact(0, '0, '0, 1, 0, 40'h40, '0, 3'd2);
    wait_idle();
    q = logq[$];
    check("t1_type", 128'(q.t), 128'd0);
    check("t1_id", 128'(q.id), 128'd2);
    check("t1_addr", 128'(q.a), 128'h40);
    check("t1_data", q.d, 128'd0);

    n0 = logq.size();
    xact(0, '0, '0, 1, 1, 40'h40, pat, 3'd2);
    xact(0, '0, '0, 1, 0, 40'h40, '0, 3'd2);
    wait_idle();
    check("t2_count", 128'(logq.size()), 128'(n0 + 2));
    q = logq[$ - 1];
    check("t2_ack_type", 128'(q.t), 128'd1);
    check("t2_ack_data", q.d, 128'd0);
    q = logq[$];
    check("t2_ld_data", q.d, pat);

    hold_lo = 3;
    xact(0, '0, '0, 1, 0, 40'h40, '0, 3'd5);
    wait_idle();
    q = logq[$ - 1];
    check("t3_inv_type", 128'(q.t), 128'd2);
    check("t3_inv_id", 128'(q.id), 128'd2);
    check("t3_inv_addr", 128'(q.a), 128'h40);
    q = logq[$];
    check("t3_ld_id", 128'(q.id), 128'd5);
    check("t3_ld_data", q.d, pat);

    xact(1, 40'h40, xd, 1, 0, 40'h40, '0, 3'd3);
    wait_idle();
    q = logq[$ - 1];
    check("t4_inv_id", 128'(q.id), 128'd5);
    check("t4_inv_type", 128'(q.t), 128'd2);
    q = logq[$];
    check("t4_ld_id", 128'(q.id), 128'd3);
    check("t4_ld_data", q.d, xd);

    xact(0, '0, '0, 1, 0, 40'h80, '0, 3'd1);
    rst = 1'b1;
    expq.delete();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_resp_valid", {127'd0, bus.resp_valid}, 128'd0);
    repeat (8) @(posedge clk);
    #1;
    n0 = logq.size();
    xact(0, '0, '0, 1, 0, 40'h40, '0, 3'd4);
    wait_idle();
    check("t5_count", 128'(logq.size()), 128'(n0 + 1));
    q = logq[$];
    check("t5_type", 128'(q.t), 128'd0);
    check("t5_data", q.d, 128'd0);

    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      r64 = {$urandom, $urandom};
      ad = r64[39:0];
      ad[7:4] = 4'($urandom % 4);
      pat = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom % 5)
        0: xact(1, ad, pat, 0, 0, '0, '0, '0);
        1: xact(1, ad, pat, 1, 0, ad, '0,
                3'($urandom_range(1, 3)));
        2: xact(0, '0, '0, 1, 1, ad, pat,
                3'($urandom_range(1, 3)));
        default: xact(0, '0, '0, 1, 0, ad, '0,
                      3'($urandom_range(1, 3)));
      endcase
    end
    wait_idle();

    n = 0;
    while (!l1_done && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("l1_done", {127'd0, l1_done}, 128'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
